// File: rtl/cmd_receive.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cmd_receive: oversampling UART receiver that assembles PKT_BYTES-byte       |
// | commands for the command FIFO. Define UART_PARITY_EN for 8E1 framing.       |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module cmd_receive #(
  parameter int OVERSAMPLE   = 16,
  parameter int PKT_BYTES    = 7,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   baud_tick,
  input  logic                   rx_data,
  output logic [8*PKT_BYTES-1:0] cmd_fifo_wr_data,
  output logic                   cmd_fifo_wr_en,
  input  logic                   cmd_fifo_full,
  output logic                   rx_busy,
  output logic                   framing_err,
  output logic                   timeout_err,
  output logic                   overflow_err,
  output logic                   parity_err
);

  localparam int HALF     = OVERSAMPLE / 2;
  localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int CW       = $clog2(PKT_BYTES + 1);
  localparam int TW       = $clog2(TO_LIMIT + 1);
  localparam int PW       = 8 * PKT_BYTES;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rx_sync, rx_prev;
  logic [SW-1:0]   sample_cnt, sample_nxt;
  logic [2:0]      bit_cnt, bit_nxt;
  logic [7:0]      shift_byte, shift_nxt;
  logic [PW-1:0]   pkt, pkt_nxt;
  logic [CW-1:0]   byte_cnt, byte_cnt_nxt;
  logic [TW-1:0]   to_cnt, to_nxt;
  logic            framing_q, framing_nxt;
  logic            timeout_q, timeout_nxt;
  logic            start_edge, pkt_done;
`ifdef UART_PARITY_EN
  logic            par_bad, par_bad_nxt;
  logic            parity_q, parity_nxt;
`endif

  // Synchronizer and edge-history flops idle high like the line itself
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_data;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_byte <= '0;
      pkt        <= '0;
      byte_cnt   <= '0;
      to_cnt     <= '0;
      framing_q  <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad    <= 1'b0;
      parity_q   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      sample_cnt <= sample_nxt;
      bit_cnt    <= bit_nxt;
      shift_byte <= shift_nxt;
      pkt        <= pkt_nxt;
      byte_cnt   <= byte_cnt_nxt;
      to_cnt     <= to_nxt;
      framing_q  <= framing_nxt;
      timeout_q  <= timeout_nxt;
`ifdef UART_PARITY_EN
      par_bad    <= par_bad_nxt;
      parity_q   <= parity_nxt;
`endif
    end
  end

  assign start_edge = rx_prev & ~rx_sync;
  assign pkt_done   = (byte_cnt == CW'(PKT_BYTES));

  always_comb begin
    state_nxt    = state;
    sample_nxt   = sample_cnt;
    bit_nxt      = bit_cnt;
    shift_nxt    = shift_byte;
    pkt_nxt      = pkt;
    byte_cnt_nxt = byte_cnt;
    to_nxt       = to_cnt;
    framing_nxt  = 1'b0;
    timeout_nxt  = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_nxt  = par_bad;
    parity_nxt   = 1'b0;
`endif
    // A finished packet is handed off (or dropped) in exactly one cycle
    if (pkt_done) byte_cnt_nxt = '0;

    case (state)
      S_IDLE: begin
        if (start_edge) begin
          state_nxt  = S_START;
          sample_nxt = '0;
          to_nxt     = '0;
`ifdef UART_PARITY_EN
          par_bad_nxt = 1'b0;
`endif
        end else if (byte_cnt != '0 && !pkt_done) begin
          if (baud_tick) begin
            if (to_cnt == TW'(TO_LIMIT - 1)) begin
              timeout_nxt  = 1'b1;
              byte_cnt_nxt = '0;
              to_nxt       = '0;
            end else begin
              to_nxt = to_cnt + TW'(1);
            end
          end
        end else begin
          to_nxt = '0;
        end
      end
      S_START: begin
        if (baud_tick) begin
          if (sample_cnt == SW'(HALF - 1)) begin
            sample_nxt = '0;
            bit_nxt    = '0;
            state_nxt  = rx_sync ? S_IDLE : S_DATA;
          end else begin
            sample_nxt = sample_cnt + SW'(1);
          end
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (sample_cnt == SW'(OVERSAMPLE - 1)) begin
            sample_nxt = '0;
            shift_nxt  = {rx_sync, shift_byte[7:1]};
            bit_nxt    = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
              state_nxt = S_PARITY;
`else
              state_nxt = S_STOP;
`endif
            end
          end else begin
            sample_nxt = sample_cnt + SW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          if (sample_cnt == SW'(OVERSAMPLE - 1)) begin
            sample_nxt  = '0;
            par_bad_nxt = (rx_sync != ^shift_byte);
            state_nxt   = S_STOP;
          end else begin
            sample_nxt = sample_cnt + SW'(1);
          end
        end
      end
`endif
      S_STOP: begin
        if (baud_tick) begin
          if (sample_cnt == SW'(OVERSAMPLE - 1)) begin
            sample_nxt = '0;
            state_nxt  = S_IDLE;
            if (!rx_sync) begin
              framing_nxt  = 1'b1;
              byte_cnt_nxt = '0;
            end else
`ifdef UART_PARITY_EN
            if (par_bad) begin
              parity_nxt   = 1'b1;
              byte_cnt_nxt = '0;
            end else
`endif
            begin
              pkt_nxt      = {pkt[PW-9:0], shift_byte};
              byte_cnt_nxt = byte_cnt + CW'(1);
            end
          end else begin
            sample_nxt = sample_cnt + SW'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cmd_fifo_wr_data = pkt;
  assign cmd_fifo_wr_en   = pkt_done & ~cmd_fifo_full;
  assign overflow_err     = pkt_done & cmd_fifo_full;
  assign framing_err      = framing_q;
  assign timeout_err      = timeout_q;
  assign rx_busy          = (state != S_IDLE);
`ifdef UART_PARITY_EN
  assign parity_err       = parity_q;
`else
  assign parity_err       = 1'b0;
`endif

endmodule
`default_nettype wire
